// File: rtl/i2s_sample_serializer_pkg.sv
// Shared definitions for the I2S sample serializer: default widths, FSM state type, counter sizing helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package i2s_sample_serializer_pkg;

  localparam int SAMPLE_W_DEF   = 16;
  localparam int FRAME_BITS_DEF = 2 * SAMPLE_W_DEF;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_sample_serializer_if.sv
// Sample capture bus: a data word qualified by a one-cycle write strobe.
// Latency: n/a (wires only).
// Backpressure: none; the consumer must accept every strobe.
interface i2s_sample_serializer_if
  import i2s_sample_serializer_pkg::*;
#(
  parameter int W = SAMPLE_W_DEF
);

  logic [W-1:0] sample_in;
  logic         wr;

  modport master (output sample_in, output wr);
  modport slave  (input  sample_in, input  wr);

endinterface

// File: rtl/i2s_sample_serializer_bclk_divider.sv
// Bit-clock divider: toggles bclk every BCLK_DIV system clocks and flags each falling edge.
// Latency: first bclk rise BCLK_DIV clocks after clear drops; fall_tick is combinational in the cycle before the fall.
// Backpressure: none; clear holds the counter and bclk at zero.
module i2s_sample_serializer_bclk_divider
  import i2s_sample_serializer_pkg::*;
#(
  parameter int BCLK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic bclk,
  output logic fall_tick
);

  localparam int DW = cnt_width(BCLK_DIV);

  logic [DW-1:0] div_cnt;
  logic          term;

  assign term      = (div_cnt == DW'(BCLK_DIV - 1));
  assign fall_tick = !reset && !clear && term && bclk;

  // Half-period counter; bclk flips on terminal count.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (term) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_sample_serializer.sv
// Captures strobed samples and streams the latest one as mono I2S (same word on L and R); optional OFFSET_BINARY_EN flips the MSB at load.
// Latency: a written sample reaches sdata (MSB) within 1 frame + 1 bclk; frame_strobe marks the load cycle itself.
// Backpressure: none; a second write before the next load overwrites the first and sets sticky overrun.
module i2s_sample_serializer
  import i2s_sample_serializer_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int BCLK_DIV = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  i2s_sample_serializer_if.slave  smp,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    sdata,
  output logic                    frame_strobe,
  output logic                    overrun
);

  localparam int FRAME_BITS = 2 * SAMPLE_W;
  localparam int BW         = cnt_width(FRAME_BITS);

  state_t                state;
  logic [SAMPLE_W-1:0]   hold;
  logic                  pending;
  logic [BW-1:0]         bit_cnt;
  logic [BW-1:0]         bit_cnt_nxt;
  logic [FRAME_BITS-1:0] shifter;
  logic [FRAME_BITS-1:0] shifter_nxt;
  logic [SAMPLE_W-1:0]   s_raw;
  logic [SAMPLE_W-1:0]   s_conv;
  logic                  run;
  logic                  fall_tick;
  logic                  load_now;
  logic                  leaving_run;

  assign run         = (state == RUN) && enable;
  assign leaving_run = (state == RUN) && !enable;

  i2s_sample_serializer_bclk_divider #(
    .BCLK_DIV (BCLK_DIV)
  ) u_div (
    .clock     (clock),
    .reset     (reset),
    .clear     (!run),
    .bclk      (bclk),
    .fall_tick (fall_tick)
  );

  // The word is loaded on the fall that moves bit_cnt 0 -> 1, giving the I2S one-bit delay.
  assign load_now     = fall_tick && (bit_cnt == '0);
  assign frame_strobe = load_now;

  // Slot counter advance, load source selection and next shifter contents.
  always_comb begin
    bit_cnt_nxt = (bit_cnt == BW'(FRAME_BITS - 1)) ? '0 : bit_cnt + 1'b1;
    s_raw       = smp.wr ? smp.sample_in : hold;
`ifdef OFFSET_BINARY_EN
    s_conv      = {~s_raw[SAMPLE_W-1], s_raw[SAMPLE_W-2:0]};
`else
    s_conv      = s_raw;
`endif
    shifter_nxt = load_now ? {s_conv, s_conv} : {shifter[FRAME_BITS-2:0], 1'b0};
  end

  // Sample capture, pending flag and sticky overrun; independent of the stream state.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold    <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (smp.wr) begin
        hold <= smp.sample_in;
      end
      if (load_now) begin
        pending <= 1'b0;
      end else if (smp.wr) begin
        pending <= 1'b1;
      end
      if (leaving_run) begin
        overrun <= 1'b0;
      end else if (smp.wr && pending && !load_now) begin
        overrun <= 1'b1;
      end
    end
  end

  // Stream FSM with slot counter, word select and serial data, all registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      lrclk   <= 1'b0;
      sdata   <= 1'b0;
      shifter <= '0;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          lrclk   <= 1'b0;
          sdata   <= 1'b0;
          shifter <= '0;
          if (enable) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (!enable) begin
            state   <= IDLE;
            bit_cnt <= '0;
            lrclk   <= 1'b0;
            sdata   <= 1'b0;
            shifter <= '0;
          end else if (fall_tick) begin
            bit_cnt <= bit_cnt_nxt;
            lrclk   <= (bit_cnt_nxt >= BW'(SAMPLE_W));
            shifter <= shifter_nxt;
            sdata   <= shifter_nxt[FRAME_BITS-1];
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_sample_serializer.sv
// Directed bench for the I2S serializer at SAMPLE_W=16, BCLK_DIV=2 (bclk period 4 clocks, frame 128 clocks).
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_i2s_sample_serializer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic bclk;
  logic lrclk;
  logic sdata;
  logic frame_strobe;
  logic overrun;

  int errors = 0;
  int checks = 0;

  logic [31:0] w;
  logic [31:0] lr;
  int          n;

  i2s_sample_serializer_if #(.W(16)) smp ();

  i2s_sample_serializer #(
    .SAMPLE_W (16),
    .BCLK_DIV (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .smp          (smp),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .frame_strobe (frame_strobe),
    .overrun      (overrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_wr(input logic [15:0] v);
    @(negedge clock);
    smp.sample_in = v;
    smp.wr        = 1'b1;
    @(posedge clock);
    #1 smp.wr = 1'b0;
  endtask

  // Returns at the negedge inside the load cycle.
  task automatic wait_strobe(input string tag);
    int  k;
    logic seen;
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 300) begin
      @(negedge clock);
      k++;
      seen = frame_strobe;
    end
    chk(tag, 32'(seen), 32'h1);
  endtask

  // Called at the load-cycle negedge; samples slots 1..32 mid-bit, first bit lands in the MSB.
  task automatic capture(output logic [31:0] word, output logic [31:0] lrw);
    @(posedge clock);
    #1 smp.wr = 1'b0;
    word = '0;
    lrw  = '0;
    for (int i = 0; i < 32; i++) begin
      if (i == 0) @(negedge clock);
      else repeat (4) @(negedge clock);
      word = {word[30:0], sdata};
      lrw  = {lrw[30:0], lrclk};
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_bclk"},   32'(bclk),         32'h0);
    chk({tag, "_lrclk"},  32'(lrclk),        32'h0);
    chk({tag, "_sdata"},  32'(sdata),        32'h0);
    chk({tag, "_strobe"}, 32'(frame_strobe), 32'h0);
    chk({tag, "_ovr"},    32'(overrun),      32'h0);
  endtask

  initial begin
    smp.sample_in = 16'h0000;
    smp.wr        = 1'b0;

    // Power-on reset.
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_idle("rst");
    reset = 1'b0;

    // Basic frame: sample written while idle, then stream started.
    do_wr(16'hA5C3);
    @(negedge clock);
    enable = 1'b1;
    @(negedge clock);
    chk("start_bclk_n1", 32'(bclk), 32'h0);
    chk("start_slot0_sdata", 32'(sdata), 32'h0);
    @(negedge clock);
    chk("start_bclk_n2", 32'(bclk), 32'h0);
    @(negedge clock);
    chk("start_bclk_rise", 32'(bclk), 32'h1);
    wait_strobe("strobe_basic");
    capture(w, lr);
    chk("basic_word", w, 32'hA5C3A5C3);
    chk("basic_lrclk", lr, 32'h0001FFFE);
    chk("basic_ovr", 32'(overrun), 32'h0);

    // Strobe period and repeat of the held sample.
    wait_strobe("strobe_period_a");
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!frame_strobe && n < 300);
    chk("strobe_period", 32'(n), 32'd128);
    capture(w, lr);
    chk("repeat_word", w, 32'hA5C3A5C3);

    // Bypass: write lands in the load cycle itself.
    wait_strobe("strobe_bypass");
    smp.sample_in = 16'h1234;
    smp.wr        = 1'b1;
    capture(w, lr);
    chk("bypass_word", w, 32'h12341234);
    chk("bypass_ovr", 32'(overrun), 32'h0);

    // Overrun: two writes in one frame.
    repeat (20) @(negedge clock);
    do_wr(16'h0001);
    chk("ovr_first_wr", 32'(overrun), 32'h0);
    do_wr(16'h0002);
    chk("ovr_set", 32'(overrun), 32'h1);
    wait_strobe("strobe_ovr");
    capture(w, lr);
    chk("ovr_word", w, 32'h00020002);
    chk("ovr_sticky", 32'(overrun), 32'h1);

    // Enable drop in slot 9 while bclk is high.
    wait_strobe("strobe_drop");
    repeat (35) @(negedge clock);
    chk("pre_drop_bclk", 32'(bclk), 32'h1);
    enable = 1'b0;
    @(negedge clock);
    chk_idle("drop");

    // Restart: slot 0 silent, held 0x0002 repeats.
    repeat (3) @(negedge clock);
    enable = 1'b1;
    @(negedge clock);
    chk("restart_slot0_sdata", 32'(sdata), 32'h0);
    wait_strobe("strobe_restart");
    capture(w, lr);
    chk("restart_word", w, 32'h00020002);
    chk("restart_ovr", 32'(overrun), 32'h0);

    // MSB conversion (build dependent).
    do_wr(16'h0000);
    wait_strobe("strobe_ob0");
    capture(w, lr);
`ifdef OFFSET_BINARY_EN
    chk("ob_word_0000", w, 32'h80008000);
`else
    chk("ob_word_0000", w, 32'h00000000);
`endif
    do_wr(16'hFFFF);
    wait_strobe("strobe_ob1");
    capture(w, lr);
`ifdef OFFSET_BINARY_EN
    chk("ob_word_ffff", w, 32'h7FFF7FFF);
`else
    chk("ob_word_ffff", w, 32'hFFFFFFFF);
`endif

    // Mid-frame reset with overrun set, then restart timing.
    repeat (40) @(negedge clock);
    do_wr(16'h0005);
    do_wr(16'h0006);
    chk("pre_rst_ovr", 32'(overrun), 32'h1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk_idle("midrst");
    reset = 1'b0;
    @(negedge clock);
    chk("rerun_bclk_n1", 32'(bclk), 32'h0);
    @(negedge clock);
    chk("rerun_bclk_n2", 32'(bclk), 32'h0);
    @(negedge clock);
    chk("rerun_bclk_rise", 32'(bclk), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
